// File: rtl/mips_mem_pkg.sv
// Shared definitions for the fetch/data memory-port arbiter: FSM state and
// owner encodings plus the default bus widths.
package mips_mem_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2,
        RESP   = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data and memory-port signals around the arbiter.
// master = arbiter side, slave = pipeline stages plus memory model.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // fetch stage
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;
    logic              if_stall;

    // memory stage
    logic                d_req;
    logic                d_we;
    logic [ADDR_W-1:0]   d_addr;
    logic [DATA_W-1:0]   d_wdata;
    logic [DATA_W/8-1:0] d_be;
    logic [DATA_W-1:0]   d_rdata;
    logic                d_ack;
    logic                mem_stall;

    // unified memory port
    logic                m_req;
    logic                m_we;
    logic [ADDR_W-1:0]   m_addr;
    logic [DATA_W-1:0]   m_wdata;
    logic [DATA_W/8-1:0] m_be;
    logic                m_ready;
    logic [DATA_W-1:0]   m_rdata;

    modport master (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be,
               m_ready, m_rdata,
        output if_rdata, if_ack, if_stall, d_rdata, d_ack, mem_stall,
               m_req, m_we, m_addr, m_wdata, m_be
    );

    modport slave (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be,
               m_ready, m_rdata,
        input  if_rdata, if_ack, if_stall, d_rdata, d_ack, mem_stall,
               m_req, m_we, m_addr, m_wdata, m_be
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and data accesses onto one multi-cycle memory port.
// Optional fetch starvation guard: define MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clock,
    input  logic               reset,
    mem_port_arbiter_if.master bus
);

    localparam int BE_W = DATA_W / 8;

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_I_BUSY = I_BUSY;
    localparam logic [1:0] ST_D_BUSY = D_BUSY;
    localparam logic [1:0] ST_RESP   = RESP;

    logic [1:0]        state;
    logic              grant_vld;
    owner_e            grant_own;
    logic              starved;

    logic              m_req_q;
    logic              m_we_q;
    logic [ADDR_W-1:0] m_addr_q;
    logic [DATA_W-1:0] m_wdata_q;
    logic [BE_W-1:0]   m_be_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              if_ack_q;
    logic              d_ack_q;

    // Grants only happen from IDLE, so a req still high during RESP is never re-served.
    always_comb begin
        grant_vld = 1'b0;
        grant_own = OWN_D;
        if (state == ST_IDLE) begin
            if (bus.d_req && !(starved && bus.if_req)) begin
                grant_vld = 1'b1;
                grant_own = OWN_D;
            end else if (bus.if_req) begin
                grant_vld = 1'b1;
                grant_own = OWN_I;
            end
        end
    end

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_cnt;

    assign starved = (starve_cnt == CNT_W'(STARVE_LIMIT));

    // Counts data grants that overtook a waiting fetch; it can never pass the
    // limit because at the limit either fetch wins or if_req is low.
    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (state == ST_IDLE) begin
            if (!bus.if_req) begin
                starve_cnt <= '0;
            end else if (grant_vld && grant_own == OWN_I) begin
                starve_cnt <= '0;
            end else if (grant_vld && grant_own == OWN_D) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end
    end
`else
    // Strict data priority; the limit has no effect in this build.
    assign starved = 1'b0 & (STARVE_LIMIT > 0);
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            m_be_q     <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            if_ack_q   <= 1'b0;
            d_ack_q    <= 1'b0;
        end else begin
            if_ack_q <= 1'b0;
            d_ack_q  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_vld) begin
                        m_req_q <= 1'b1;
                        if (grant_own == OWN_D) begin
                            m_we_q    <= bus.d_we;
                            m_addr_q  <= bus.d_addr;
                            m_wdata_q <= bus.d_wdata;
                            m_be_q    <= bus.d_be;
                            state     <= ST_D_BUSY;
                        end else begin
                            m_we_q   <= 1'b0;
                            m_addr_q <= bus.if_addr;
                            m_be_q   <= '1;
                            state    <= ST_I_BUSY;
                        end
                    end
                end
                ST_I_BUSY: begin
                    if (bus.m_ready) begin
                        m_req_q    <= 1'b0;
                        if_rdata_q <= bus.m_rdata;
                        if_ack_q   <= 1'b1;
                        state      <= ST_RESP;
                    end
                end
                ST_D_BUSY: begin
                    if (bus.m_ready) begin
                        m_req_q <= 1'b0;
                        // Stores complete without disturbing the last load result.
                        if (!m_we_q) begin
                            d_rdata_q <= bus.m_rdata;
                        end
                        d_ack_q <= 1'b1;
                        state   <= ST_RESP;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.m_req     = m_req_q;
    assign bus.m_we      = m_we_q;
    assign bus.m_addr    = m_addr_q;
    assign bus.m_wdata   = m_wdata_q;
    assign bus.m_be      = m_be_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.if_stall  = bus.if_req & ~if_ack_q;
    assign bus.mem_stall = bus.d_req & ~d_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed per-cycle vector table for mem_port_arbiter plus hand-written
// starvation / priority sequences (expectations follow MEM_ARB_STARVE_GUARD_EN).
module tb_mem_port_arbiter;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus();

    mem_port_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .STARVE_LIMIT(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {
        logic        rst;
        logic        if_req;
        logic [31:0] if_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic [3:0]  d_be;
        logic        m_ready;
        logic [31:0] m_rdata;
        logic        e_m_req;
        logic        e_m_we;
        logic [31:0] e_m_addr;
        logic [31:0] e_m_wdata;
        logic [3:0]  e_m_be;
        logic        e_if_ack;
        logic [31:0] e_if_rdata;
        logic        e_if_stall;
        logic        e_d_ack;
        logic [31:0] e_d_rdata;
        logic        e_mem_stall;
        logic        full;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;
    int   row    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (step %0d): got %h, expected %h", name, row, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.if_req  = 1'b0;
        bus.if_addr = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        bus.d_be    = '0;
        bus.m_ready = 1'b0;
        bus.m_rdata = '0;
    endtask

    initial begin
        vec_t v;
        int   data_grants;
        int   data_before_fetch;
        logic fetch_seen;
        logic fetch_after_drop;
        logic prev_req;

        idle_inputs();
        reset = 1'b1;

        // ---- build the vector table ----
        v = '{default: '0};
        v.full = 1'b1;
        vecs.push_back(v);                                   // reset state
        v.full = 1'b0;
        // fetch only
        v.if_req = 1'b1; v.if_addr = 32'h100; v.e_if_stall = 1'b1;
        vecs.push_back(v);
        v.m_ready = 1'b1; v.m_rdata = 32'h2002000A;
        v.e_m_req = 1'b1; v.e_m_we = 1'b0; v.e_m_addr = 32'h100;
        vecs.push_back(v);
        v.m_ready = 1'b0; v.m_rdata = '0; v.e_m_req = 1'b0;
        v.e_if_ack = 1'b1; v.e_if_rdata = 32'h2002000A; v.e_if_stall = 1'b0;
        vecs.push_back(v);                                   // stale if_req in RESP
        v.if_req = 1'b0; v.e_if_ack = 1'b0;
        vecs.push_back(v);                                   // no duplicate grant
        vecs.push_back(v);
        // store with 3 wait cycles
        v.d_req = 1'b1; v.d_we = 1'b1; v.d_addr = 32'h40;
        v.d_wdata = 32'hDEADBEEF; v.d_be = 4'hF; v.e_mem_stall = 1'b1;
        vecs.push_back(v);
        v.e_m_req = 1'b1; v.e_m_we = 1'b1; v.e_m_addr = 32'h40;
        v.e_m_wdata = 32'hDEADBEEF; v.e_m_be = 4'hF;
        vecs.push_back(v);
        vecs.push_back(v);
        vecs.push_back(v);
        v.m_ready = 1'b1; v.m_rdata = 32'h12345678;
        vecs.push_back(v);
        v.m_ready = 1'b0; v.m_rdata = '0; v.e_m_req = 1'b0;
        v.e_d_ack = 1'b1; v.e_mem_stall = 1'b0;
        vecs.push_back(v);                                   // d_rdata stays 0
        v.d_req = 1'b0; v.d_we = 1'b0; v.e_d_ack = 1'b0;
        vecs.push_back(v);
        // conflict: data load wins, fetch after RESP
        v.if_req = 1'b1; v.if_addr = 32'h200; v.d_req = 1'b1; v.d_addr = 32'h80;
        v.e_if_stall = 1'b1; v.e_mem_stall = 1'b1;
        vecs.push_back(v);
        v.m_ready = 1'b1; v.m_rdata = 32'hCAFEF00D;
        v.e_m_req = 1'b1; v.e_m_we = 1'b0; v.e_m_addr = 32'h80;
        vecs.push_back(v);
        v.m_ready = 1'b0; v.m_rdata = '0; v.e_m_req = 1'b0;
        v.e_d_ack = 1'b1; v.e_d_rdata = 32'hCAFEF00D; v.e_mem_stall = 1'b0;
        vecs.push_back(v);                                   // no grant in RESP
        v.d_req = 1'b0; v.e_d_ack = 1'b0;
        vecs.push_back(v);
        v.e_m_req = 1'b1; v.e_m_addr = 32'h200;
        vecs.push_back(v);
        v.m_ready = 1'b1; v.m_rdata = 32'h0BADC0DE;
        vecs.push_back(v);
        v.m_ready = 1'b0; v.m_rdata = '0; v.if_req = 1'b0; v.e_m_req = 1'b0;
        v.e_if_ack = 1'b1; v.e_if_rdata = 32'h0BADC0DE; v.e_if_stall = 1'b0;
        vecs.push_back(v);
        // m_ready while idle must be ignored
        v.m_ready = 1'b1; v.m_rdata = 32'hFFFFFFFF; v.e_if_ack = 1'b0;
        vecs.push_back(v);
        v.m_ready = 1'b0; v.m_rdata = '0;
        vecs.push_back(v);
        // reset in the middle of a data load, then a late m_ready
        v.d_req = 1'b1; v.d_addr = 32'h300; v.e_mem_stall = 1'b1;
        vecs.push_back(v);
        v.rst = 1'b1; v.e_m_req = 1'b1; v.e_m_we = 1'b0; v.e_m_addr = 32'h300;
        vecs.push_back(v);
        v.rst = 1'b0; v.d_req = 1'b0; v.m_ready = 1'b1; v.m_rdata = 32'h55AA55AA;
        v.e_m_req = 1'b0; v.e_mem_stall = 1'b0; v.e_if_rdata = '0; v.e_d_rdata = '0;
        v.e_m_addr = '0; v.e_m_wdata = '0; v.e_m_be = '0; v.e_m_we = 1'b0; v.full = 1'b1;
        vecs.push_back(v);
        v.m_ready = 1'b0; v.m_rdata = '0;
        vecs.push_back(v);

        repeat (2) @(posedge clock);

        // ---- apply the table ----
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clock);
            row         = i;
            reset       = vecs[i].rst;
            bus.if_req  = vecs[i].if_req;
            bus.if_addr = vecs[i].if_addr;
            bus.d_req   = vecs[i].d_req;
            bus.d_we    = vecs[i].d_we;
            bus.d_addr  = vecs[i].d_addr;
            bus.d_wdata = vecs[i].d_wdata;
            bus.d_be    = vecs[i].d_be;
            bus.m_ready = vecs[i].m_ready;
            bus.m_rdata = vecs[i].m_rdata;
            #1;
            chk("m_req",     32'(bus.m_req),     32'(vecs[i].e_m_req));
            chk("if_ack",    32'(bus.if_ack),    32'(vecs[i].e_if_ack));
            chk("if_stall",  32'(bus.if_stall),  32'(vecs[i].e_if_stall));
            chk("d_ack",     32'(bus.d_ack),     32'(vecs[i].e_d_ack));
            chk("mem_stall", 32'(bus.mem_stall), 32'(vecs[i].e_mem_stall));
            chk("if_rdata",  bus.if_rdata,       vecs[i].e_if_rdata);
            chk("d_rdata",   bus.d_rdata,        vecs[i].e_d_rdata);
            if (vecs[i].e_m_req || vecs[i].full) begin
                chk("m_we",   32'(bus.m_we), 32'(vecs[i].e_m_we));
                chk("m_addr", bus.m_addr,    vecs[i].e_m_addr);
            end
            if ((vecs[i].e_m_req && vecs[i].e_m_we) || vecs[i].full) begin
                chk("m_wdata", bus.m_wdata,   vecs[i].e_m_wdata);
                chk("m_be",    32'(bus.m_be), 32'(vecs[i].e_m_be));
            end
        end

        // ---- back-to-back loads while fetch waits ----
        row               = vecs.size();
        data_grants       = 0;
        data_before_fetch = -1;
        fetch_seen        = 1'b0;
        prev_req          = 1'b0;
        @(negedge clock);
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h400;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'h500;
        for (int c = 0; c < 60; c++) begin
            if (c > 0) @(negedge clock);
            #1;
            if (bus.m_req && !prev_req) begin
                if (bus.m_addr == 32'h500) begin
                    data_grants++;
                end else if (bus.m_addr == 32'h400 && !fetch_seen) begin
                    fetch_seen        = 1'b1;
                    data_before_fetch = data_grants;
                end
            end
            prev_req    = bus.m_req;
            bus.m_ready = bus.m_req;
            if (c >= 45 && bus.d_ack) begin
                bus.d_req = 1'b0;
                break;
            end
        end
        chk("d_req_released_at_ack", 32'(bus.d_req), 32'd0);
`ifdef MEM_ARB_STARVE_GUARD_EN
        chk("guard_fetch_granted", 32'(fetch_seen), 32'd1);
        chk("guard_data_before_fetch", 32'(data_before_fetch), 32'd4);
`else
        chk("strict_fetch_never_granted", 32'(fetch_seen), 32'd0);
        chk("strict_many_data_grants", 32'(data_grants >= 12), 32'd1);
`endif

        // ---- once data stops, fetch must get the port ----
        fetch_after_drop = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            #1;
            if (bus.m_req && bus.m_addr == 32'h400) fetch_after_drop = 1'b1;
            bus.m_ready = bus.m_req;
        end
        chk("fetch_after_data_drop", 32'(fetch_after_drop), 32'd1);

        idle_inputs();
        repeat (4) @(posedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter sharing a single-ported unified memory between the fetch stage (instruction reads) and the memory stage (data loads/stores) of the 5-stage pipeline. It serialises the two requesters onto one multi-cycle memory port, returns read data to the owner, and generates the fetch and memory-stage stall signals that freeze the pipeline buffers while an access is pending.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_LIMIT, 4, max consecutive data grants while fetch waits (guard build only)
- clock  in  1  pipeline clock (gated clock from clock_state)
- reset  in  1  synchronous, active-high
- if_req  in  1  fetch read request; held with if_addr stable until if_ack
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  instruction word, valid in the if_ack cycle
- if_ack  out  1  one-cycle completion pulse to fetch
- if_stall  out  1  if_req & ~if_ack
- d_req  in  1  data request; held with d_we/d_addr/d_wdata/d_be stable until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_be  in  DATA_W/8  store byte enables
- d_rdata  out  DATA_W  load data, valid in the d_ack cycle
- d_ack  out  1  one-cycle completion pulse to memory stage
- mem_stall  out  1  d_req & ~d_ack
- m_req  out  1  memory command valid; held until m_ready
- m_we, m_addr, m_wdata, m_be  out  1/ADDR_W/DATA_W/DATA_W/8  registered command fields
- m_ready  in  1  memory completes access this cycle; m_rdata valid
- m_rdata  in  DATA_W  memory read data

## Operation
- States: IDLE, I_BUSY, D_BUSY, RESP.
- IDLE: if d_req (and no starvation override) -> latch data command, D_BUSY; else if if_req -> latch fetch command, I_BUSY; else stay.
- I_BUSY/D_BUSY: m_req=1, command registers constant; on m_ready -> register m_rdata into owner's rdata (loads/fetch only; stores leave d_rdata unchanged), pulse owner's ack next cycle, go RESP.
- RESP: ack pulse cycle; no grant made (requester's req may still be stale-high); -> IDLE.
- m_ready ignored when m_req=0.
- Requests may be dropped before grant; once granted the requester must hold req until ack.
- if_stall/mem_stall are combinational from req and ack only.

## Timing
- Reset: state IDLE; m_req, m_we, if_ack, d_ack = 0; m_addr, m_wdata, m_be, if_rdata, d_rdata = 0; starve counter 0.
- Request seen in IDLE at cycle N -> m_req high in N+1.
- m_ready at cycle M (>= N+1) -> ack and rdata in M+1 (RESP) -> IDLE at M+2.
- Minimum access with zero-wait memory: 3 cycles req-to-next-grant; ack latency 2 cycles.
- Simultaneous if_req and d_req in IDLE: data wins (oldest instruction), subject to guard.
- Reset mid-access: next cycle IDLE, m_req=0, acks not issued; late m_ready discarded.

## Configuration
- MEM_ARB_STARVE_GUARD_EN defined: counter increments on each data grant made while if_req=1, clears on fetch grant or when if_req=0 in IDLE; when counter == STARVE_LIMIT and both request, fetch is granted instead.
- Undefined: strict data priority, counter and STARVE_LIMIT unused.

## Structure
- Shared package mips_mem_pkg: state enum (IDLE, I_BUSY, D_BUSY, RESP), owner encoding (OWN_I, OWN_D), default ADDR_W/DATA_W.
- Single module; starvation counter inline under the macro, no sub-module.

## Test plan
- Fetch only: if_req, if_addr=0x100, m_ready one cycle after m_req, m_rdata=0x2002000A -> if_ack pulse 2 cycles after request, if_rdata=0x2002000A, if_stall high until ack.
- Store: d_req, d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF, d_be=0xF, m_ready after 3 wait cycles -> m_we=1, m_addr=0x40, d_ack one cycle after m_ready, d_rdata unchanged.
- Conflict: if_req and d_req (load 0x80) same cycle -> data served first, fetch granted in cycle after RESP; no grant in RESP cycle.
- Starvation (guard on, STARVE_LIMIT=4): d_req held continuously with back-to-back loads while if_req high -> fetch granted after 4th data access; guard off -> fetch never granted while d_req high.
- Reset mid-access: reset while D_BUSY, then m_ready -> m_req=0 next cycle, no d_ack, all outputs at reset values.
- Stale request: requester holds req one extra cycle after ack -> no duplicate grant.
